// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Imported by the controller RTL.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  // The halt opcode is all ones. Users slice the low W bits of this constant.
  localparam int unsigned            HALT_MAX_W = 64;
  localparam logic [HALT_MAX_W-1:0]  HALT_INSTR = '1;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Signal bundle for the fetch controller: program control, branch, ROM and status.
// The master modport is the sequencer side; the slave modport is the controller side.
interface fetch_ctrl_if #(
  parameter int unsigned A  = 10,
  parameter int unsigned W  = 9,
  parameter int unsigned CW = 16
);
  logic          start;
  logic [A-1:0]  start_addr;
  logic          stall;
  logic          branch_en;
  logic          branch_rel;
  logic [A-1:0]  target;
  logic [7:0]    offset;
  logic [W-1:0]  inst;
  logic [A-1:0]  inst_addr;
  logic          busy;
  logic          done;
  logic [CW-1:0] cycle_count;

  modport master (
    output start, start_addr, stall, branch_en, branch_rel, target, offset, inst,
    input  inst_addr, busy, done, cycle_count
  );

  modport slave (
    input  start, start_addr, stall, branch_en, branch_rel, target, offset, inst,
    output inst_addr, busy, done, cycle_count
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that saturates at all ones instead of wrapping.
// Clear takes priority over En; Reset is synchronous and active-high.
module sat_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Clear,
  input  logic          En,
  output logic [CW-1:0] Count
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (Clear) begin
      count_d = '0;
    end else if (En && (count_q != '1)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: registered PC with sequential, absolute and
// PC-relative redirects, a halt opcode, stall hold and a saturating run-cycle counter.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned A  = 10,
  parameter int unsigned W  = 9,
  parameter int unsigned CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [A-1:0]  StartAddr,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic          BranchRel,
  input  logic [A-1:0]  Target,
  input  logic [7:0]    Offset,
  input  logic [W-1:0]  InstIn,
  output logic [A-1:0]  InstAddress,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] CycleCount
);

  localparam logic [W-1:0] HaltOp = HALT_INSTR[W-1:0];

  state_e       state_q, state_d;
  logic [A-1:0] pc_q, pc_d;
  logic [A-1:0] off_ext;
  logic         is_halt;
  logic         cnt_clr;
  logic         cnt_en;

  assign off_ext = A'($signed(Offset));
  assign is_halt = (InstIn == HaltOp);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = StartAddr;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        // A stalled cycle freezes everything, so the halt/branch decode only
        // matters once Stall drops.
        if (!Stall) begin
          cnt_en = 1'b1;
          if (is_halt) begin
            state_d = HALT;
          end else if (BranchEn) begin
            pc_d = BranchRel ? (pc_q + off_ext) : Target;
          end else begin
            pc_d = pc_q + A'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  sat_counter #(
    .CW(CW)
  ) u_cycles (
    .Clk  (Clk),
    .Reset(Reset),
    .Clear(cnt_clr),
    .En   (cnt_en),
    .Count(CycleCount)
  );

  assign InstAddress = pc_q;
  assign Busy        = (state_q == RUN);
  assign Done        = (state_q == HALT);

endmodule
